// File: rtl/mem_access_unit.sv
// MEM-stage front end for the 2048x32 data RAM: LOAD/STORE, stack PUSH/POP and
// two-word INT_SAVE / RTI_RESTORE, with stack pointer ownership and bounds protection.
module mem_access_unit #(
  parameter int                ADDR_W   = 11,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] SP_RESET = 11'h7FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wdata2,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              stall,
  output logic [ADDR_W-1:0] sp,
  output logic              addr_err
);

  localparam logic [2:0] OP_LOAD = 3'd1, OP_STORE = 3'd2, OP_PUSH = 3'd3,
                         OP_POP  = 3'd4, OP_INT   = 3'd5, OP_RTI   = 3'd6;

  localparam logic [ADDR_W-1:0] ONE    = 1;
  localparam logic [ADDR_W-1:0] TWO    = 2;
  localparam logic [ADDR_W-1:0] SP_LIM = SP_RESET - ONE;

  typedef enum logic {IDLE, SECOND} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] sp_n, sp_p1, sp_p2, sp_m1;
  logic              rv_n, err_n;
  logic [DATA_W-1:0] rd_n, rd2_n;

  assign sp_p1 = sp + ONE;
  assign sp_p2 = sp + TWO;
  assign sp_m1 = sp - ONE;

  always_comb begin
    state_n   = state;
    sp_n      = sp;
    rv_n      = 1'b0;
    err_n     = 1'b0;
    rd_n      = rsp_data;
    rd2_n     = rsp_data2;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    mem_wen   = 1'b0;
    stall     = 1'b0;

    if (state == SECOND) begin
      // The request is held upstream, so req_op still names the two-word op.
      state_n = IDLE;
      case (req_op)
        OP_INT: begin
          mem_addr  = sp_m1;
          mem_wdata = req_wdata2;
          mem_wen   = 1'b1;
          sp_n      = sp - TWO;
          rv_n      = 1'b1;
        end
        OP_RTI: begin
          mem_addr = sp_p2;
          rd_n     = mem_rdata;
          sp_n     = sp_p2;
          rv_n     = 1'b1;
        end
        default: ;
      endcase
    end else if (req_valid) begin
      case (req_op)
        OP_LOAD: begin
          rd_n = mem_rdata;
          rv_n = 1'b1;
        end
        OP_STORE: begin
          mem_wen = 1'b1;
          rv_n    = 1'b1;
        end
        OP_PUSH: begin
          rv_n = 1'b1;
          if (sp == '0) err_n = 1'b1;
          else begin
            mem_addr = sp;
            mem_wen  = 1'b1;
            sp_n     = sp_m1;
          end
        end
        OP_POP: begin
          rv_n = 1'b1;
          if (sp == SP_RESET) begin
            err_n = 1'b1;
            rd_n  = '0;
          end else begin
            mem_addr = sp_p1;
            rd_n     = mem_rdata;
            sp_n     = sp_p1;
          end
        end
        OP_INT: begin
          if (sp <= ONE) begin
            err_n = 1'b1;
            rv_n  = 1'b1;
          end else begin
            mem_addr = sp;
            mem_wen  = 1'b1;
            stall    = 1'b1;
            state_n  = SECOND;
          end
        end
        OP_RTI: begin
          if (sp >= SP_LIM) begin
            err_n = 1'b1;
            rv_n  = 1'b1;
            rd_n  = '0;
            rd2_n = '0;
          end else begin
            mem_addr = sp_p1;
            rd2_n    = mem_rdata;
            stall    = 1'b1;
            state_n  = SECOND;
          end
        end
        default: ;
      endcase
    end

    if (rst) begin
      mem_wen = 1'b0;
      stall   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sp        <= SP_RESET;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_data2 <= '0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_n;
      sp        <= sp_n;
      rsp_valid <= rv_n;
      rsp_data  <= rd_n;
      rsp_data2 <= rd2_n;
      addr_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 2048x32 RAM model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [10:0] req_addr;
  logic [31:0] req_wdata, req_wdata2;
  logic [31:0] mem_rdata;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        rsp_valid;
  logic [31:0] rsp_data, rsp_data2;
  logic        stall;
  logic [10:0] sp;
  logic        addr_err;

  logic [31:0] ram [0:2047];
  int tests = 0;
  int fails = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wdata2(req_wdata2),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_data2(rsp_data2), .stall(stall), .sp(sp), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_wen) ram[mem_addr] <= mem_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [10:0] a,
                       input logic [31:0] d, input logic [31:0] d2);
    req_valid = v; req_op = op; req_addr = a; req_wdata = d; req_wdata2 = d2;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 3'd5, 11'h0, 32'h1, 32'h2);
    tests++; if (mem_wen !== 1'b0) begin fails++; $display("FAIL rst_wen got %b exp 0", mem_wen); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b exp 0", stall); end
    tick(); tick();
    tests++; if (sp !== 11'h7FF) begin fails++; $display("FAIL rst_sp got %h exp 7ff", sp); end
    tests++; if ({rsp_valid, addr_err} !== 2'b00) begin fails++; $display("FAIL rst_flags got %b exp 00", {rsp_valid, addr_err}); end
    tests++; if ({rsp_data, rsp_data2} !== 64'h0) begin fails++; $display("FAIL rst_data got %h exp 0", {rsp_data, rsp_data2}); end
    rst = 1'b0;
    drive(1'b0, 3'd0, 11'h0, 32'h0, 32'h0);
  endtask

  task automatic test_store_port();
    drive(1'b1, 3'd2, 11'h0, 32'h0000_00A5, 32'h0);
    tests++; if ({mem_wen, mem_addr} !== {1'b1, 11'h0}) begin fails++; $display("FAIL store_req got wen=%b addr=%h exp 1/000", mem_wen, mem_addr); end
    tick();
    drive(1'b0, 3'd0, 11'h0, 32'h0, 32'h0);
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL store_rsp got %b exp 1", rsp_valid); end
    tests++; if (ram[0][7:0] !== 8'hA5) begin fails++; $display("FAIL store_port got %h exp a5", ram[0][7:0]); end
    tests++; if (sp !== 11'h7FF) begin fails++; $display("FAIL store_sp got %h exp 7ff", sp); end
  endtask

  task automatic test_push_pop();
    drive(1'b1, 3'd3, 11'h0, 32'h1111_1111, 32'h0);
    tests++; if ({mem_wen, mem_addr} !== {1'b1, 11'h7FF}) begin fails++; $display("FAIL push1_addr got wen=%b addr=%h exp 1/7ff", mem_wen, mem_addr); end
    tick();
    drive(1'b1, 3'd3, 11'h0, 32'h2222_2222, 32'h0);
    tests++; if ({mem_wen, mem_addr} !== {1'b1, 11'h7FE}) begin fails++; $display("FAIL push2_addr got wen=%b addr=%h exp 1/7fe", mem_wen, mem_addr); end
    tick();
    tests++; if (sp !== 11'h7FD) begin fails++; $display("FAIL push_sp got %h exp 7fd", sp); end
    drive(1'b1, 3'd4, 11'h0, 32'h0, 32'h0);
    tests++; if ({mem_wen, mem_addr} !== {1'b0, 11'h7FE}) begin fails++; $display("FAIL pop1_addr got wen=%b addr=%h exp 0/7fe", mem_wen, mem_addr); end
    tick();
    tests++; if (rsp_data !== 32'h2222_2222) begin fails++; $display("FAIL pop1_data got %h exp 22222222", rsp_data); end
    tick();
    drive(1'b0, 3'd0, 11'h0, 32'h0, 32'h0);
    tests++; if (rsp_data !== 32'h1111_1111) begin fails++; $display("FAIL pop2_data got %h exp 11111111", rsp_data); end
    tests++; if ({sp, addr_err} !== {11'h7FF, 1'b0}) begin fails++; $display("FAIL pop_sp got sp=%h err=%b exp 7ff/0", sp, addr_err); end
    tick();
    tests++; if ({rsp_valid, rsp_data} !== {1'b0, 32'h1111_1111}) begin fails++; $display("FAIL idle_hold got v=%b d=%h exp 0/11111111", rsp_valid, rsp_data); end
  endtask

  task automatic test_int_rti();
    drive(1'b1, 3'd5, 11'h0, 32'h0000_0040, 32'h0000_0005);
    tests++; if ({stall, mem_wen, mem_addr} !== {2'b11, 11'h7FF}) begin fails++; $display("FAIL int_c1 got st=%b wen=%b addr=%h exp 1/1/7ff", stall, mem_wen, mem_addr); end
    tick();
    tests++; if ({stall, mem_wen, mem_addr, rsp_valid} !== {2'b01, 11'h7FE, 1'b0}) begin fails++; $display("FAIL int_c2 got st=%b wen=%b addr=%h v=%b exp 0/1/7fe/0", stall, mem_wen, mem_addr, rsp_valid); end
    tests++; if (mem_wdata !== 32'h5) begin fails++; $display("FAIL int_c2_wdata got %h exp 5", mem_wdata); end
    tick();
    drive(1'b0, 3'd0, 11'h0, 32'h0, 32'h0);
    tests++; if ({rsp_valid, sp} !== {1'b1, 11'h7FD}) begin fails++; $display("FAIL int_done got v=%b sp=%h exp 1/7fd", rsp_valid, sp); end
    tests++; if ({ram[2047], ram[2046]} !== {32'h40, 32'h5}) begin fails++; $display("FAIL int_ram got %h exp 0000004000000005", {ram[2047], ram[2046]}); end
    drive(1'b1, 3'd6, 11'h0, 32'h0, 32'h0);
    tests++; if ({stall, mem_wen, mem_addr} !== {2'b10, 11'h7FE}) begin fails++; $display("FAIL rti_c1 got st=%b wen=%b addr=%h exp 1/0/7fe", stall, mem_wen, mem_addr); end
    tick();
    tests++; if ({stall, mem_addr} !== {1'b0, 11'h7FF}) begin fails++; $display("FAIL rti_c2 got st=%b addr=%h exp 0/7ff", stall, mem_addr); end
    tick();
    drive(1'b0, 3'd0, 11'h0, 32'h0, 32'h0);
    tests++; if ({rsp_data, rsp_data2} !== {32'h40, 32'h5}) begin fails++; $display("FAIL rti_data got %h exp 0000004000000005", {rsp_data, rsp_data2}); end
    tests++; if ({rsp_valid, sp} !== {1'b1, 11'h7FF}) begin fails++; $display("FAIL rti_sp got v=%b sp=%h exp 1/7ff", rsp_valid, sp); end
  endtask

  task automatic test_stack_bounds();
    drive(1'b1, 3'd4, 11'h0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 3'd0, 11'h0, 32'h0, 32'h0);
    tests++; if ({sp, rsp_data, addr_err, rsp_valid} !== {11'h7FF, 32'h0, 2'b11}) begin fails++; $display("FAIL pop_empty got sp=%h d=%h err=%b v=%b exp 7ff/0/1/1", sp, rsp_data, addr_err, rsp_valid); end
    tick();
    tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL err_clear got %b exp 0", addr_err); end
    drive(1'b1, 3'd6, 11'h0, 32'h0, 32'h0);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rti_empty_stall got %b exp 0", stall); end
    tick();
    tests++; if ({rsp_data2, addr_err, sp} !== {32'h0, 1'b1, 11'h7FF}) begin fails++; $display("FAIL rti_empty got d2=%h err=%b sp=%h exp 0/1/7ff", rsp_data2, addr_err, sp); end
    for (int i = 0; i < 2047; i++) begin
      drive(1'b1, 3'd3, 11'h0, i, 32'h0);
      tick();
    end
    tests++; if (sp !== 11'h000) begin fails++; $display("FAIL fill_sp got %h exp 000", sp); end
    drive(1'b1, 3'd3, 11'h0, 32'hFFFF_FFFF, 32'h0);
    tests++; if ({mem_wen, stall} !== 2'b00) begin fails++; $display("FAIL push_full_wen got wen=%b st=%b exp 0/0", mem_wen, stall); end
    tick();
    tests++; if ({addr_err, rsp_valid, sp} !== {2'b11, 11'h000}) begin fails++; $display("FAIL push_full got err=%b v=%b sp=%h exp 1/1/000", addr_err, rsp_valid, sp); end
    tests++; if (ram[0] !== 32'h0000_00A5) begin fails++; $display("FAIL port_kept got %h exp a5", ram[0]); end
    drive(1'b1, 3'd4, 11'h0, 32'h0, 32'h0);
    tick();
    tests++; if ({rsp_data, sp} !== {32'h7FE, 11'h001}) begin fails++; $display("FAIL pop_at0 got d=%h sp=%h exp 7fe/001", rsp_data, sp); end
    drive(1'b1, 3'd5, 11'h0, 32'h99, 32'h98);
    tests++; if ({mem_wen, stall} !== 2'b00) begin fails++; $display("FAIL int_sp1 got wen=%b st=%b exp 0/0", mem_wen, stall); end
    tick();
    drive(1'b0, 3'd0, 11'h0, 32'h0, 32'h0);
    tests++; if ({addr_err, rsp_valid, sp} !== {2'b11, 11'h001}) begin fails++; $display("FAIL int_sp1_rsp got err=%b v=%b sp=%h exp 1/1/001", addr_err, rsp_valid, sp); end
  endtask

  task automatic test_load_store();
    drive(1'b1, 3'd2, 11'h123, 32'hDEAD_BEEF, 32'h0);
    tick();
    drive(1'b1, 3'd1, 11'h123, 32'h0, 32'h0);
    tests++; if ({mem_wen, mem_addr} !== {1'b0, 11'h123}) begin fails++; $display("FAIL load_addr got wen=%b addr=%h exp 0/123", mem_wen, mem_addr); end
    tick();
    drive(1'b1, 3'd7, 11'h055, 32'h0, 32'h0);
    tests++; if ({rsp_valid, rsp_data, addr_err} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin fails++; $display("FAIL load_data got v=%b d=%h err=%b exp 1/deadbeef/0", rsp_valid, rsp_data, addr_err); end
    tests++; if ({mem_wen, mem_addr} !== {1'b0, 11'h055}) begin fails++; $display("FAIL rsvd_addr got wen=%b addr=%h exp 0/055", mem_wen, mem_addr); end
    tick();
    drive(1'b0, 3'd0, 11'h0, 32'h0, 32'h0);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rsvd_rsp got %b exp 0", rsp_valid); end
  endtask

  task automatic test_rst_second();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ram[2046] = 32'hCAFE_0000;
    drive(1'b1, 3'd5, 11'h0, 32'h77, 32'h99);
    tick();
    rst = 1'b1;
    #1;
    tests++; if ({mem_wen, stall} !== 2'b00) begin fails++; $display("FAIL rst2_comb got wen=%b st=%b exp 0/0", mem_wen, stall); end
    tick();
    rst = 1'b0;
    drive(1'b0, 3'd0, 11'h0, 32'h0, 32'h0);
    tests++; if (ram[2046] !== 32'hCAFE_0000) begin fails++; $display("FAIL rst2_ram got %h exp cafe0000", ram[2046]); end
    tests++; if ({sp, rsp_valid, addr_err, rsp_data, rsp_data2} !== {11'h7FF, 66'h0}) begin fails++; $display("FAIL rst2_regs got sp=%h v=%b e=%b d=%h d2=%h exp 7ff/0", sp, rsp_valid, addr_err, rsp_data, rsp_data2); end
    drive(1'b1, 3'd1, 11'h7FF, 32'h0, 32'h0);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst2_idle got stall=%b exp 0", stall); end
    tick();
    drive(1'b0, 3'd0, 11'h0, 32'h0, 32'h0);
    tests++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h77}) begin fails++; $display("FAIL rst2_load got v=%b d=%h exp 1/77", rsp_valid, rsp_data); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
    rst = 1'b1;
    req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0; req_wdata2 = '0;
    test_reset();
    test_store_port();
    test_push_pop();
    test_int_rti();
    test_stack_bounds();
    test_load_store();
    test_rst_second();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
